// File: rtl/arm_bus_pkg.sv
// rtl/arm_bus_pkg.sv - shared constants and types for the memory arbiter
package arm_bus_pkg;

  localparam int N_REQ       = 3;
  localparam int REQ_IFETCH  = 0;
  localparam int REQ_DATA    = 1;
  localparam int REQ_DBG     = 2;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    if (oh[REQ_DBG])       return 2'd2;
    else if (oh[REQ_DATA]) return 2'd1;
    else                   return 2'd0;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rtl/mem_arbiter_rr_picker.sv - round-robin winner selection starting after last
module rr_picker
  import arm_bus_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       last,
  output logic [N_REQ-1:0] winner
);

  logic [1:0] first, second, third;

  always_comb begin
    first  = (last   == 2'd2) ? 2'd0 : last   + 2'd1;
    second = (first  == 2'd2) ? 2'd0 : first  + 2'd1;
    third  = (second == 2'd2) ? 2'd0 : second + 2'd1;
    winner = '0;
    if (req[first])       winner[first]  = 1'b1;
    else if (req[second]) winner[second] = 1'b1;
    else if (req[third])  winner[third]  = 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - three-requester round-robin memory arbiter with access timeout
module mem_arbiter
  import arm_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0]              we,
  input  logic [N_REQ-1:0][ADDR_W-1:0]  addr,
  input  logic [N_REQ-1:0][DATA_W-1:0]  wdata,
  output logic [N_REQ-1:0]              gnt,
  output logic [N_REQ-1:0]              done,
  output logic [N_REQ-1:0]              err,
  output logic [DATA_W-1:0]             rdata,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_ready
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  arb_state_t       state, state_nxt;
  logic [1:0]       owner, last, win_idx;
  logic [CNT_W-1:0] cnt;
  logic [N_REQ-1:0] winner, owner_oh;
  logic             complete, expire, launch;

  rr_picker u_picker (
    .req    (req),
    .last   (last),
    .winner (winner)
  );

  assign win_idx  = onehot_to_idx(winner);
  assign owner_oh = 3'b001 << owner;
  assign complete = (state == BUSY) && mem_ready;
  // Completion wins over an expiring counter in the same cycle.
  assign expire   = (state == BUSY) && !mem_ready && (cnt == CNT_MAX);
  assign launch   = (req != '0) && ((state == IDLE) || complete);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (launch) state_nxt = BUSY;
      BUSY: begin
        if (complete)    state_nxt = launch ? BUSY : IDLE;
        else if (expire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      rdata     <= '0;
      owner     <= 2'd0;
      last      <= 2'd2;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      gnt  <= launch   ? winner   : '0;
      done <= complete ? owner_oh : '0;
      err  <= expire   ? owner_oh : '0;
      if (complete) rdata <= mem_rdata;
      if (launch) begin
        owner     <= win_idx;
        last      <= win_idx;
        cnt       <= '0;
        mem_req   <= 1'b1;
        mem_we    <= we[win_idx];
        mem_addr  <= addr[win_idx];
        mem_wdata <= wdata[win_idx];
      end else if (complete || expire) begin
        cnt     <= '0;
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end else if (state == BUSY) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        req, we;
  logic [2:0][31:0]  addr, wdata;
  logic [2:0]        gnt, done, err;
  logic [31:0]       rdata, mem_addr, mem_wdata, mem_rdata;
  logic              mem_req, mem_we, mem_ready;

  int tests = 0;
  int fails = 0;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " gnt"},       32'(gnt), 32'h0);
    chk({tag, " done"},      32'(done), 32'h0);
    chk({tag, " err"},       32'(err), 32'h0);
    chk({tag, " mem_req"},   32'(mem_req), 32'h0);
    chk({tag, " mem_we"},    32'(mem_we), 32'h0);
    chk({tag, " mem_addr"},  mem_addr, 32'h0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, " rdata"},     rdata, 32'h0);
  endtask

  initial begin
    rst = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    #3;
    chk_all_zero("reset");
    step(); step();
    rst = 1'b1;

    // single read by ifetch
    req = 3'b001; addr[0] = 32'h100;
    step();
    chk("rd gnt", 32'(gnt), 32'h1);
    chk("rd mem_req", 32'(mem_req), 32'h1);
    chk("rd mem_addr", mem_addr, 32'h100);
    chk("rd mem_we", 32'(mem_we), 32'h0);
    req = '0;
    step();
    chk("rd gnt pulse", 32'(gnt), 32'h0);
    chk("rd done early", 32'(done), 32'h0);
    mem_ready = 1'b1; mem_rdata = 32'hCAFE0001;
    step();
    chk("rd done", 32'(done), 32'h1);
    chk("rd rdata", rdata, 32'hCAFE0001);
    chk("rd mem_req off", 32'(mem_req), 32'h0);
    mem_ready = 1'b0;
    step();
    chk("rd done pulse", 32'(done), 32'h0);

    // data write held through wait states
    req = 3'b010; we = 3'b010; addr[1] = 32'h2000; wdata[1] = 32'hDEADBEEF;
    step();
    chk("wr gnt", 32'(gnt), 32'h2);
    chk("wr mem_addr", mem_addr, 32'h2000);
    chk("wr mem_we", 32'(mem_we), 32'h1);
    chk("wr mem_wdata", mem_wdata, 32'hDEADBEEF);
    req = '0; we = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wr hold mem_req", 32'(mem_req), 32'h1);
      chk("wr hold mem_we", 32'(mem_we), 32'h1);
      chk("wr hold wdata", mem_wdata, 32'hDEADBEEF);
      chk("wr hold done", 32'(done), 32'h0);
    end
    mem_ready = 1'b1; mem_rdata = 32'h0;
    step();
    chk("wr done", 32'(done), 32'h2);
    chk("wr mem_we off", 32'(mem_we), 32'h0);
    chk("wr mem_req off", 32'(mem_req), 32'h0);
    mem_ready = 1'b0;

    // timeout on debug access with ifetch pending
    req = 3'b100; addr[2] = 32'h300;
    step();
    chk("to gnt", 32'(gnt), 32'h4);
    req = 3'b001; addr[0] = 32'h104;
    for (int i = 1; i < 16; i++) begin
      step();
      chk("to wait err", 32'(err), 32'h0);
      chk("to wait gnt", 32'(gnt), 32'h0);
      chk("to wait mem_req", 32'(mem_req), 32'h1);
    end
    step();
    chk("to err", 32'(err), 32'h4);
    chk("to done", 32'(done), 32'h0);
    chk("to mem_req off", 32'(mem_req), 32'h0);
    step();
    chk("to next gnt", 32'(gnt), 32'h1);
    chk("to err pulse", 32'(err), 32'h0);
    chk("to next addr", mem_addr, 32'h104);
    req = '0;

    // completion on the last allowed cycle beats the timeout
    for (int i = 1; i < 16; i++) begin
      step();
      chk("edge wait err", 32'(err), 32'h0);
      chk("edge wait done", 32'(done), 32'h0);
    end
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    step();
    chk("edge done", 32'(done), 32'h1);
    chk("edge err", 32'(err), 32'h0);
    chk("edge rdata", rdata, 32'h12345678);
    mem_ready = 1'b0;
    step();
    chk("edge err after", 32'(err), 32'h0);

    // reset in the middle of an access
    req = 3'b010; addr[1] = 32'h2004;
    step();
    chk("mr gnt", 32'(gnt), 32'h2);
    req = '0;
    step();
    rst = 1'b0; mem_ready = 1'b1;
    #1;
    chk_all_zero("mid reset");
    step();
    chk("mr held done", 32'(done), 32'h0);
    chk("mr held err", 32'(err), 32'h0);
    rst = 1'b1; mem_ready = 1'b0; req = 3'b101;
    step();
    chk("post rst gnt", 32'(gnt), 32'h1);
    chk("post rst done", 32'(done), 32'h0);
    req = 3'b100;
    mem_ready = 1'b1; mem_rdata = 32'h55AA55AA;
    step();
    chk("b2b done", 32'(done), 32'h1);
    chk("b2b gnt", 32'(gnt), 32'h4);
    chk("b2b mem_req", 32'(mem_req), 32'h1);
    chk("b2b rdata", rdata, 32'h55AA55AA);

    // all three requesting with memory always ready
    req = 3'b111;
    step();
    chk("rot done0", 32'(done), 32'h4);
    chk("rot gnt0", 32'(gnt), 32'h1);
    chk("rot req0", 32'(mem_req), 32'h1);
    step();
    chk("rot gnt1", 32'(gnt), 32'h2);
    chk("rot done1", 32'(done), 32'h1);
    chk("rot req1", 32'(mem_req), 32'h1);
    step();
    chk("rot gnt2", 32'(gnt), 32'h4);
    chk("rot req2", 32'(mem_req), 32'h1);
    step();
    chk("rot gnt3", 32'(gnt), 32'h1);
    chk("rot req3", 32'(mem_req), 32'h1);
    req = '0;
    step();
    chk("drain done", 32'(done), 32'h1);
    chk("drain gnt", 32'(gnt), 32'h0);
    chk("drain mem_req", 32'(mem_req), 32'h0);
    step();
    chk("idle ready done", 32'(done), 32'h0);
    chk("idle ready err", 32'(err), 32'h0);
    mem_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of requester and memory ports.
REQ-002 Parameter: DATA_W, 32, data width of requester and memory ports.
REQ-003 Parameter: TIMEOUT, 16, max cycles a memory access may take before abort (>=2).
REQ-004 Port: clk  input  1  single clock, all state on rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-low reset.
REQ-006 Port: req  input  3  per-requester request; bit0 = instruction fetch, bit1 = data load/store, bit2 = debug.
REQ-007 Port: we  input  3  per-requester write enable, sampled with req.
REQ-008 Port: addr  input  3 x ADDR_W  per-requester address.
REQ-009 Port: wdata  input  3 x DATA_W  per-requester write data.
REQ-010 Port: gnt  output  3  one-hot, one-cycle pulse: request accepted, requester may change its inputs.
REQ-011 Port: done  output  3  one-hot, one-cycle pulse: access finished, rdata valid.
REQ-012 Port: err  output  3  one-hot, one-cycle pulse: access aborted by timeout.
REQ-013 Port: rdata  output  DATA_W  read data, valid only in the done cycle.
REQ-014 Port: mem_req, mem_we  output  1 each  memory command strobe and write enable.
REQ-015 Port: mem_addr, mem_wdata  output  ADDR_W / DATA_W  registered memory command.
REQ-016 Port: mem_rdata  input  DATA_W; mem_ready  input  1  memory completes the access in the cycle it is high.

Function
REQ-017 FSM SHALL have two states: IDLE (no access) and BUSY (one access outstanding).
REQ-018 In IDLE with req != 0, SHALL pick the winner round-robin, starting at (last+1) mod 3; at the next edge: state=BUSY, owner=winner, last=winner, mem_* loaded from the winner's inputs, gnt[winner]=1 for exactly one cycle.
REQ-019 Requester SHALL hold req/we/addr/wdata stable until gnt; losers keep waiting, and no request is dropped.
REQ-020 In BUSY, mem_req, mem_we, mem_addr and mem_wdata SHALL stay constant until completion or abort; mem_we SHALL be 0 whenever mem_req is 0.
REQ-021 When mem_ready=1 in BUSY: next cycle done[owner]=1 and rdata=mem_rdata as sampled; mem_ready in IDLE SHALL be ignored.
REQ-022 Back-to-back: if req != 0 in the mem_ready cycle, arbitration SHALL occur in that same cycle (excluding owner's already-granted request only via round-robin order); next cycle shows done of old owner and gnt of new winner together, with mem_req staying 1.
REQ-023 Timeout counter SHALL clear on entry to BUSY and increment each BUSY cycle without mem_ready; at count TIMEOUT-1 without mem_ready: next cycle err[owner]=1, mem_req=0, state=IDLE, no done.
REQ-024 mem_ready and timeout in the same cycle: completion SHALL win (done, no err).
REQ-025 Latency: req to gnt = 1 cycle; mem_ready to done = 1 cycle; minimum req-to-done = 2 cycles.
REQ-026 With all three requesting continuously, grants SHALL rotate 0,1,2,0,...; no requester waits more than two foreign accesses.

Reset
REQ-027 rst=0 SHALL immediately force state=IDLE, last=2 (requester 0 first), counter=0, and gnt, done, err, mem_req, mem_we, mem_addr, mem_wdata, rdata all 0.
REQ-028 Reset mid-access SHALL abort silently (no done/err); the first edge after release SHALL only arbitrate.

Structure
REQ-029 Shared package arm_bus_pkg SHALL hold N_REQ=3, requester index constants (REQ_IFETCH, REQ_DATA, REQ_DBG), the arb_state_t enum and the default TIMEOUT.
REQ-030 A combinational sub-module rr_picker SHALL compute the one-hot winner from (req, last); all other logic is in mem_arbiter.

Verification
REQ-031 Reset, then req=3'b001, addr[0]=0x100, mem_ready=1 one cycle after mem_req -> gnt=001 at +1, mem_addr=0x100, done=001 with rdata=mem_rdata two cycles after gnt.
REQ-032 req=3'b111 held, mem_ready always 1 -> gnt sequence 001,010,100,001 in consecutive grant slots, mem_req never drops.
REQ-033 Data write: we[1]=1, addr=0x2000, wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF held through 3 wait cycles until mem_ready, then done=010.
REQ-034 mem_ready never asserted, TIMEOUT=16 -> err[owner] pulse 16 cycles after gnt, mem_req=0, no done; a next pending req is granted afterwards.
REQ-035 rst=0 asserted during BUSY -> all outputs 0 immediately; after release req=3'b101 -> gnt=001 first.
REQ-036 mem_ready on the exact timeout cycle -> done pulse, no err.
